bip2_program_loader: RTL

BIP2_PROGRAM_LOADER -- requirements
Module: bip2_program_loader

---
 rtl/bip2_pkg.sv | 12 +
 rtl/bip2_program_loader.sv | 97 +++++++++
 2 files changed

// File: rtl/bip2_pkg.sv
// Shared state encoding and default widths for the BIP2 program loader.
package bip2_pkg;
    localparam int DEFAULT_OPERAND_ADDRESS_WIDTH  = 11;
    localparam int DEFAULT_INSTRUCTION_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } loader_state_t;
endpackage

// File: rtl/bip2_program_loader.sv
// Streams a program into BIP2 instruction memory while holding the CPU in reset,
// then releases the CPU once the requested number of words has been written.
module bip2_program_loader
    import bip2_pkg::*;
#(
    parameter int OPERAND_ADDRESS_WIDTH  = DEFAULT_OPERAND_ADDRESS_WIDTH,
    parameter int INSTRUCTION_DATA_WIDTH = DEFAULT_INSTRUCTION_DATA_WIDTH
) (
    input  logic                              clock_in,
    input  logic                              reset_in,
    input  logic                              start_in,
    input  logic [OPERAND_ADDRESS_WIDTH:0]    word_count_in,
    input  logic [INSTRUCTION_DATA_WIDTH-1:0] word_in,
    input  logic                              word_valid_in,
    output logic                              word_ready_out,
    output logic [OPERAND_ADDRESS_WIDTH-1:0]  imem_address_out,
    output logic [INSTRUCTION_DATA_WIDTH-1:0] imem_instruction_out,
    output logic                              imem_wr_out,
    output logic                              cpu_reset_out,
    output logic                              busy_out,
    output logic                              done_out,
    output logic                              error_out
);
    localparam int AW = OPERAND_ADDRESS_WIDTH;

    // The count is one bit wider than the address so a full memory image is expressible.
    localparam logic [AW:0] MAX_COUNT = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};

    loader_state_t state;
    logic [AW:0]   count_latched;
    logic [AW:0]   accepted;
    logic [AW:0]   accepted_next;
    logic          count_ok;
    logic          handshake;

    assign count_ok       = (word_count_in != '0) && (word_count_in <= MAX_COUNT);
    assign word_ready_out = (state == LOAD);
    assign handshake      = word_ready_out && word_valid_in;
    assign accepted_next  = accepted + ONE;

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state                <= IDLE;
            count_latched        <= '0;
            accepted             <= '0;
            imem_wr_out          <= 1'b0;
            imem_address_out     <= '0;
            imem_instruction_out <= '0;
            cpu_reset_out        <= 1'b0;
            busy_out             <= 1'b0;
            done_out             <= 1'b0;
            error_out            <= 1'b0;
        end else begin
            imem_wr_out <= 1'b0;
            case (state)
                IDLE, RUN: begin
                    if (start_in) begin
                        if (count_ok) begin
                            state         <= LOAD;
                            count_latched <= word_count_in;
                            accepted      <= '0;
                            error_out     <= 1'b0;
                            busy_out      <= 1'b1;
                            done_out      <= 1'b0;
                            cpu_reset_out <= 1'b0;
                        end else begin
                            error_out <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // The write lands one cycle after the handshake; the final one
                    // completes during RELEASE, so the counter never wraps into an extra write.
                    if (handshake) begin
                        imem_wr_out          <= 1'b1;
                        imem_address_out     <= accepted[AW-1:0];
                        imem_instruction_out <= word_in;
                        accepted             <= accepted_next;
                        if (accepted_next == count_latched) begin
                            state <= RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    state         <= RUN;
                    busy_out      <= 1'b0;
                    done_out      <= 1'b1;
                    cpu_reset_out <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
